// File: rtl/key_digit_capture.sv
// Turns PS/2 number-key presses into a two-digit display register with clear/delete
// editing and typematic suppression, and drives the scan stage's digit-select count.
module key_digit_capture #(
  parameter int REFRESH_BITS = 17
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       key_valid,
  input  logic [8:0] key_code,
  input  logic       key_break,
  output logic [3:0] digit_lo,
  output logic [3:0] digit_hi,
  output logic [1:0] scan_sel,
  output logic       key_err
);

  typedef enum logic {
    IDLE,
    HELD
  } state_t;

  typedef enum logic [1:0] {
    KIND_DIGIT,
    KIND_CLEAR,
    KIND_DELETE,
    KIND_OTHER
  } kind_t;

  localparam logic [3:0]              BLANK   = 4'hF;
  localparam logic [REFRESH_BITS-1:0] CNT_ONE = REFRESH_BITS'(1);

  state_t                  state_q;
  state_t                  state_d;
  logic [8:0]              held_code_q;
  kind_t                   kind;
  logic [3:0]              dec_digit;
  logic                    make_ev;
  logic                    brk_ev;
  logic                    same_key;
  logic                    accept;
  logic [3:0]              lo_d;
  logic [3:0]              hi_d;
  logic                    err_d;
  logic [REFRESH_BITS-1:0] refresh_cnt;

  // Main-row and keypad digits share one decode; extended codes are filtered out below.
  always_comb begin
    kind      = KIND_OTHER;
    dec_digit = 4'h0;
    case (key_code[7:0])
      8'h45, 8'h70: begin kind = KIND_DIGIT; dec_digit = 4'd0; end
      8'h16, 8'h69: begin kind = KIND_DIGIT; dec_digit = 4'd1; end
      8'h1E, 8'h72: begin kind = KIND_DIGIT; dec_digit = 4'd2; end
      8'h26, 8'h7A: begin kind = KIND_DIGIT; dec_digit = 4'd3; end
      8'h25, 8'h6B: begin kind = KIND_DIGIT; dec_digit = 4'd4; end
      8'h2E, 8'h73: begin kind = KIND_DIGIT; dec_digit = 4'd5; end
      8'h36, 8'h74: begin kind = KIND_DIGIT; dec_digit = 4'd6; end
      8'h3D, 8'h6C: begin kind = KIND_DIGIT; dec_digit = 4'd7; end
      8'h3E, 8'h75: begin kind = KIND_DIGIT; dec_digit = 4'd8; end
      8'h46, 8'h7D: begin kind = KIND_DIGIT; dec_digit = 4'd9; end
      8'h76:        kind = KIND_CLEAR;
      8'h66:        kind = KIND_DELETE;
      default:      kind = KIND_OTHER;
    endcase
  end

  // A make is acted on unless it repeats the key already held down.
  assign make_ev  = key_valid & ~key_code[8] & ~key_break;
  assign brk_ev   = key_valid & ~key_code[8] & key_break;
  assign same_key = (key_code == held_code_q);
  assign accept   = make_ev & ((state_q == IDLE) | ~same_key);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      held_code_q <= 9'd0;
    end else begin
      state_q <= state_d;
      if (accept) begin
        held_code_q <= key_code;
      end
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (accept) state_d = HELD;
      HELD:    if (brk_ev && same_key) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    lo_d  = digit_lo;
    hi_d  = digit_hi;
    err_d = 1'b0;
    if (accept) begin
      case (kind)
        KIND_DIGIT: begin
          hi_d = digit_lo;
          lo_d = dec_digit;
        end
        KIND_CLEAR: begin
          hi_d = BLANK;
          lo_d = BLANK;
        end
        KIND_DELETE: begin
          lo_d = digit_hi;
          hi_d = BLANK;
        end
        default: err_d = 1'b1;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      digit_lo <= BLANK;
      digit_hi <= BLANK;
      key_err  <= 1'b0;
    end else begin
      digit_lo <= lo_d;
      digit_hi <= hi_d;
      key_err  <= err_d;
    end
  end

  // scan_sel steps on the cycle the prescaler rolls over to zero.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      refresh_cnt <= '0;
      scan_sel    <= 2'd0;
    end else begin
      refresh_cnt <= refresh_cnt + CNT_ONE;
      if (refresh_cnt == {REFRESH_BITS{1'b1}}) begin
        scan_sel <= scan_sel + 2'd1;
      end
    end
  end

endmodule

// File: doc/key_digit_capture.md
# key_digit_capture

Captures PS/2 keyboard make/break events and turns number-key presses into a two-digit display register. It also generates the 2-bit digit-select count for the four-digit seven-segment scan stage that sits directly downstream. Outputs `digit_lo` and `digit_hi` feed that stage's two rightmost digit inputs, and `scan_sel` feeds its select input. Typematic repeats are suppressed; Escape and Backspace give clear and delete editing.

## Interface
- `REFRESH_BITS`, default 17: width of the refresh prescaler. `scan_sel` advances once every 2^REFRESH_BITS cycles.
- `clk` input 1: system clock; all state updates on its rising edge.
- `rst_n` input 1: reset, synchronous, active-low.
- `key_valid` input 1: one-cycle strobe; a decoded key event is present this cycle.
- `key_code` input 9: bit 8 is the E0 (extended) prefix flag; bits 7:0 are the PS/2 set-2 make code.
- `key_break` input 1: qualifies `key_valid`; 1 = release (break), 0 = press (make).
- `digit_lo` output 4: most recently entered digit; 4'hF = blank.
- `digit_hi` output 4: previously entered digit; 4'hF = blank.
- `scan_sel` output 2: digit-select count for the display scan stage.
- `key_err` output 1: one-cycle pulse on a make of an unmapped key.

## Operation
- Digit map (non-extended only):
  - Main-row 0–9: 0x45, 0x16, 0x1E, 0x26, 0x25, 0x2E, 0x36, 0x3D, 0x3E, 0x46.
  - Keypad 0–9: 0x70, 0x69, 0x72, 0x7A, 0x6B, 0x73, 0x74, 0x6C, 0x75, 0x7D.
- Control keys (non-extended): Escape 0x76 = CLEAR; Backspace 0x66 = DELETE.
- Every event with `key_code[8]`=1 is ignored entirely: no state change, no `key_err`.
- Hold tracker FSM, with `held_code` (9 bits) register:
  - IDLE + make of any code → act on the key, store `held_code`, go to HELD.
  - HELD + make with code equal to `held_code` → typematic repeat; ignore it and stay in HELD.
  - HELD + make with a different code → rollover; act on the key, update `held_code`, stay in HELD.
  - HELD + break equal to `held_code` → go to IDLE.
  - Any other break → ignored.
- Actions on an accepted make:
  - Digit d: `digit_hi` ← `digit_lo`; `digit_lo` ← d.
  - CLEAR: both digits ← 4'hF.
  - DELETE: `digit_lo` ← `digit_hi`; `digit_hi` ← 4'hF.
  - Any other code: digits unchanged; `key_err` = 1 for one cycle. The FSM still tracks the key as held.
- Shifting in a digit while `digit_lo` is blank moves the blank into `digit_hi`. The digits are never interpreted numerically.
- Refresh: `REFRESH_BITS`-wide free-running counter. `scan_sel` increments by 1 (mod 4, wrapping 3→0) on the cycle the counter wraps to 0. The counter is independent of key activity.

## Timing
- Reset (`rst_n`=0 at a clock edge) sets:
  - `digit_lo`=`digit_hi`=4'hF, `scan_sel`=0, `key_err`=0;
  - prescaler=0, FSM=IDLE, `held_code`=0.
- Reset overrides a coincident `key_valid`. The first event is accepted on the first edge with `rst_n`=1.
- Latency: the digit update and `key_err` become visible one cycle after the `key_valid` edge (registered outputs). No combinational path from inputs to outputs.
- `key_valid` may assert on consecutive cycles; each event is processed in its own cycle with no backpressure.
- `scan_sel` sequence: first change 2^REFRESH_BITS cycles after reset release, then every 2^REFRESH_BITS cycles.
- Inputs are synchronous to `clk`; upstream performs any synchronisation.

## Test plan
- Reset → `digit_lo`=`digit_hi`=F, `scan_sel`=0. Sim with `REFRESH_BITS`=3 → `scan_sel` reads 1,2,3,0 at cycles 8,16,24,32.
- Make 0x16, break 0x16, make 0x1E, break 0x1E → after each make `{hi,lo}` = {F,1} then {1,2}. `key_err` never pulses.
- Make 0x25, then three further makes of 0x25 (typematic), then break 0x25 → `{hi,lo}` = {F,4}. No further change until the break; the next make of 0x25 gives {4,4}.
- Rollover: make 0x70, make 0x69 without a break, then break 0x70 → {0,1}. A later make 0x69 is treated as a repeat and ignored until break 0x69.
- {1,2} + DELETE (0x66) → {F,1}; DELETE again → {F,F}. Digits 7,8 → {7,8}; ESC (0x76) → {F,F}.
- Make 0x1C (unmapped) → `key_err`=1 for exactly one cycle, digits unchanged. Make 0x16 with `key_code[8]`=1 → no change, no error. `rst_n`=0 coincident with a digit make → digits stay F.
